// File: rtl/pito_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : pito_uart_loader
// Purpose  : UART byte-stream loader that writes framed 32-bit words into the
//            SoC instruction or data RAM programming port.
// Options  : PITO_LOADER_CHKSUM_EN adds a trailing XOR checksum byte per frame.
// Revision : 1.0 - initial release
// ============================================================================
module pito_uart_loader #(
    parameter int          DATA_W    = 32,
    parameter int          IMEM_AW   = 12,
    parameter int          DMEM_AW   = 12,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               imem_req,
    output logic               imem_we,
    output logic [3:0]         imem_be,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [DATA_W-1:0]  imem_wdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [3:0]         dmem_be,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_TGT   = 4'd1,
        S_ALO   = 4'd2,
        S_AHI   = 4'd3,
        S_CLO   = 4'd4,
        S_CHI   = 4'd5,
        S_DATA  = 4'd6,
        S_WRITE = 4'd7,
`ifdef PITO_LOADER_CHKSUM_EN
        S_CHK   = 4'd8,
`endif
        S_DONE  = 4'd9
    } state_t;

    // State that follows the last payload byte or word of a frame.
`ifdef PITO_LOADER_CHKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t              state_q, state_d;
    logic                tgt_q, tgt_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         word_q, word_d;
    logic                rx_ready_q, rx_ready_d;
    logic                imem_req_q, imem_req_d;
    logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                dmem_req_q, dmem_req_d;
    logic [DMEM_AW-1:0]  dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef PITO_LOADER_CHKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic                w_xfer;
    logic [31:0]         w_word;

    assign w_xfer = rx_valid & rx_ready_q;
    assign w_word = {rx_data, word_q};

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        err_d        = err_q;
        imem_req_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_req_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_xfer && rx_data == SYNC_BYTE) begin
                    state_d    = S_TGT;
                    err_d      = 1'b0;
                    byte_cnt_d = 2'd0;
                end
            end
            S_TGT: begin
                if (w_xfer) begin
                    if (rx_data > 8'd1) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tgt_d   = rx_data[0];
                        state_d = S_ALO;
                    end
                end
            end
            S_ALO: begin
                if (w_xfer) begin
                    addr_d[7:0] = rx_data;
                    state_d     = S_AHI;
                end
            end
            S_AHI: begin
                if (w_xfer) begin
                    addr_d[15:8] = rx_data;
                    state_d      = S_CLO;
                end
            end
            S_CLO: begin
                if (w_xfer) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = S_CHI;
                end
            end
            S_CHI: begin
                if (w_xfer) begin
                    cnt_d[15:8] = rx_data;
                    state_d     = ({rx_data, cnt_q[7:0]} == 16'd0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    word_d     = {rx_data, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // The write is launched here so it is on the port during WRITE.
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        if (tgt_q) begin
                            dmem_req_d   = 1'b1;
                            dmem_addr_d  = addr_q[DMEM_AW-1:0];
                            dmem_wdata_d = w_word;
                        end else begin
                            imem_req_d   = 1'b1;
                            imem_addr_d  = addr_q[IMEM_AW-1:0];
                            imem_wdata_d = w_word;
                        end
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_TAIL : S_DATA;
            end
`ifdef PITO_LOADER_CHKSUM_EN
            S_CHK: begin
                if (w_xfer) begin
                    if (rx_data == chk_q) begin
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = (state_d != S_WRITE) && (state_d != S_DONE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

`ifdef PITO_LOADER_CHKSUM_EN
    // Running XOR over every byte after SYNC up to the checksum byte itself.
    always_comb begin
        chk_d = chk_q;
        if (state_q == S_IDLE) begin
            chk_d = 8'd0;
        end else if (w_xfer && state_q != S_CHK) begin
            chk_d = chk_q ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            addr_q       <= 16'd0;
            cnt_q        <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'd0;
            rx_ready_q   <= 1'b0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef PITO_LOADER_CHKSUM_EN
            chk_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            rx_ready_q   <= rx_ready_d;
            imem_req_q   <= imem_req_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_req_q   <= dmem_req_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef PITO_LOADER_CHKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_req   = imem_req_q;
    assign imem_we    = imem_req_q;
    assign imem_be    = {4{imem_req_q}};
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_req_q;
    assign dmem_be    = {4{dmem_req_q}};
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pito_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pito_uart_loader
// Purpose  : Self-checking bench for pito_uart_loader (frame-level model plus
//            directed frames; honours PITO_LOADER_CHKSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pito_uart_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_req, imem_we, dmem_req, dmem_we;
    logic [3:0]  imem_be, dmem_be;
    logic [11:0] imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata;
    logic        busy, done, err;

    pito_uart_loader dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_req(imem_req), .imem_we(imem_we), .imem_be(imem_be),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tgt;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    int          done_cnt     = 0;
    int          exp_done_cnt = 0;
    logic        exp_err      = 1'b0;
    logic [7:0]  fr[$];
    logic [31:0] imem_mem[4096];
    logic [31:0] dmem_mem[4096];
    logic        xfer_at_edge = 1'b0;
    logic        prev_write   = 1'b0;
    logic        prev_done    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transfer marker sampled with flop semantics at the active edge.
    always @(posedge clk) xfer_at_edge <= rx_valid & rx_ready;

    // Single compare process: every write and every done pulse is checked.
    always @(negedge clk) begin
        if (rst) begin
            prev_write = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (imem_req || dmem_req) begin
                wr_t e;
                chk("one_req", {31'd0, imem_req & dmem_req}, 32'd0);
                chk("wr_latency", {31'd0, xfer_at_edge}, 32'd1);
                chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: imem=%0b dmem=%0b expected none", imem_req, dmem_req);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_target", {31'd0, dmem_req}, {31'd0, e.tgt});
                    if (dmem_req) begin
                        chk("wr_addr", {20'd0, dmem_addr}, {20'd0, e.addr});
                        chk("wr_data", dmem_wdata, e.data);
                        chk("wr_be_we", {27'd0, dmem_be, dmem_we}, 32'h1F);
                        dmem_mem[dmem_addr] = dmem_wdata;
                    end else begin
                        chk("wr_addr", {20'd0, imem_addr}, {20'd0, e.addr});
                        chk("wr_data", imem_wdata, e.data);
                        chk("wr_be_we", {27'd0, imem_be, imem_we}, 32'h1F);
                        imem_mem[imem_addr] = imem_wdata;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", {31'd0, prev_write | xfer_at_edge}, 32'd1);
                chk("done_width", {31'd0, prev_done}, 32'd0);
                chk("done_busy_ready", {30'd0, busy, rx_ready}, 32'd2);
            end
            prev_write = imem_req | dmem_req;
            prev_done  = done;
        end
    end

    // Frame-level model: derives all writes and the outcome from the byte list.
    task automatic model_frame();
        logic [15:0] a, c;
        logic [7:0]  x;
        logic        ok;
        wr_t         w;
        if (fr[1] > 8'd1) begin
            exp_err = 1'b1;
            return;
        end
        a = {fr[3], fr[2]};
        c = {fr[5], fr[4]};
        for (int i = 0; i < int'(c); i++) begin
            w.tgt  = fr[1][0];
            w.addr = a[11:0] + 12'(i);
            w.data = {fr[9+4*i], fr[8+4*i], fr[7+4*i], fr[6+4*i]};
            exp_q.push_back(w);
        end
        ok = 1'b1;
`ifdef PITO_LOADER_CHKSUM_EN
        x = 8'd0;
        for (int k = 1; k < fr.size() - 1; k++) x = x ^ fr[k];
        ok = (x == fr[fr.size()-1]);
`else
        x = 8'd0;
`endif
        exp_err = ~ok;
        if (ok) exp_done_cnt++;
    endtask

    task automatic add_chk(input logic [7:0] flip);
`ifdef PITO_LOADER_CHKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int k = 1; k < fr.size(); k++) x = x ^ fr[k];
        fr.push_back(x ^ flip);
`else
        if (flip != 8'd0) $display("note: checksum flip ignored");
`endif
    endtask

    // Called and returns at a falling edge; the byte moves on the next rising edge with rx_ready high.
    task automatic send(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: rx_ready=%0b expected 1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
    endtask

    task automatic run_frame(input string name);
        model_frame();
        for (int i = 0; i < fr.size(); i++) begin
            send(fr[i]);
            if (i == 2) chk({name, "_busy_mid"}, {31'd0, busy}, 32'd1);
        end
        settle();
        chk({name, "_done_count"}, done_cnt, exp_done_cnt);
        chk({name, "_writes_left"}, exp_q.size(), 32'd0);
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        imem_mem[16] = 0; imem_mem[17] = 0; imem_mem[4095] = 0; imem_mem[0] = 0;
        dmem_mem[0]  = 0;
        repeat (2) @(negedge clk);
        chk("reset_ready_busy_done_err", {28'd0, rx_ready, busy, done, err}, 32'd0);
        chk("reset_reqs", {26'd0, imem_req, dmem_req, imem_be}, 32'd0);
        chk("reset_data", imem_wdata | dmem_wdata | {20'd0, imem_addr | dmem_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, rx_ready}, 32'd1);

        // 1) two imem words
        fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        add_chk(8'h00);
        run_frame("t1");
        chk("t1_word0", imem_mem[16], 32'h44332211);
        chk("t1_word1", imem_mem[17], 32'h88776655);

        // 2) zero-count dmem frame
        fr = '{8'hA5, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00};
        add_chk(8'h00);
        run_frame("t2");

        // 3) junk, bad target, then a good dmem frame
        send(8'h00);
        send(8'hFF);
        settle();
        chk("t3_junk_idle", {30'd0, busy, err}, 32'd0);
        fr = '{8'hA5, 8'h02};
        run_frame("t3a");
        chk("t3a_err_literal", {31'd0, err}, 32'd1);
        fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_chk(8'h00);
        run_frame("t3b");
        chk("t3b_dmem0", dmem_mem[0], 32'hEFBEADDE);

        // 4) address wrap at the top of a 12-bit space
        fr = '{8'hA5, 8'h00, 8'hFF, 8'h0F, 8'h02, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        add_chk(8'h00);
        run_frame("t4");
        chk("t4_word_fff", imem_mem[4095], 32'h04030201);
        chk("t4_word_000", imem_mem[0], 32'h08070605);

        // 5) reset after two data bytes
        fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
        for (int i = 0; i < fr.size(); i++) send(fr[i]);
        rst = 1'b1;
        #1;
        chk("t5_rst_flags", {28'd0, rx_ready, busy, done, err}, 32'd0);
        chk("t5_rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        chk("t5_after_rst", {29'd0, busy, done, err}, 32'd0);
        chk("t5_no_write", exp_q.size() + done_cnt, exp_done_cnt);
        imem_mem[16] = 0; imem_mem[17] = 0;
        fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        add_chk(8'h00);
        run_frame("t5");
        chk("t5_word0", imem_mem[16], 32'h44332211);
        chk("t5_word1", imem_mem[17], 32'h88776655);

`ifdef PITO_LOADER_CHKSUM_EN
        // 6) corrupted checksum: words land, err set, no done
        imem_mem[16] = 0; imem_mem[17] = 0;
        fr = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h00,
               8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        chk("t6_chk_literal", {24'd0, 8'h00 ^ 8'h10 ^ 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33
                                ^ 8'h44 ^ 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88}, 32'h00000000 | {24'd0, fr[1]^fr[2]^fr[3]^fr[4]^fr[5]^fr[6]^fr[7]^fr[8]^fr[9]^fr[10]^fr[11]^fr[12]^fr[13]});
        add_chk(8'h01);
        run_frame("t6");
        chk("t6_err_literal", {31'd0, err}, 32'd1);
        chk("t6_word0", imem_mem[16], 32'h44332211);
        chk("t6_word1", imem_mem[17], 32'h88776655);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
